// File: rtl/sd_route_pkg.sv
// Shared types and default parameters for the SD SPI route controller.
package sd_route_pkg;

    typedef enum logic [1:0] {
        PHYS    = 2'd0,
        DRAIN_V = 2'd1,
        VIRT    = 2'd2,
        DRAIN_P = 2'd3
    } route_state_t;

    localparam int DEF_QUIET_CYCLES = 64;
    localparam int DEF_ACT_TIMEOUT  = 1000000;
    localparam int DEF_CNT_W        = 20;

endpackage

// File: rtl/sd_route_ctrl_act_timer.sv
// SD activity timer: any toggle on MOSI/MISO restarts a saturating counter;
// sd_act_o stays high until the counter reaches ACT_TIMEOUT.
module sd_act_timer
    import sd_route_pkg::*;
#(
    parameter int ACT_TIMEOUT = DEF_ACT_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic mosi_i,
    input  logic miso_i,
    output logic sd_act_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ACT_TIMEOUT);

    logic             mosi_q;
    logic             miso_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sd_act_q;
    logic             toggle;

    always_comb begin
        toggle = (mosi_i != mosi_q) || (miso_i != miso_q);
        cnt_d  = cnt_q;
        if (toggle) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // MISO idles high on an SD bus, so its history starts high to avoid a
    // spurious activity flash straight out of reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mosi_q   <= 1'b0;
            miso_q   <= 1'b1;
            cnt_q    <= LIMIT;
            sd_act_q <= 1'b0;
        end else begin
            mosi_q   <= mosi_i;
            miso_q   <= miso_i;
            cnt_q    <= cnt_d;
            sd_act_q <= (cnt_d < LIMIT);
        end
    end

    assign sd_act_o = sd_act_q;

endmodule

// File: rtl/sd_route_ctrl.sv
// Routes the core SPI port to the physical SD slot or the virtual sd_card,
// swapping only after the bus is quiet. Optional macro: SD_MISO_SYNC_EN.
module sd_route_ctrl
    import sd_route_pkg::*;
#(
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
    parameter int ACT_TIMEOUT  = DEF_ACT_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic img_mounted,
    input  logic img_size_nz,
    input  logic spi_sck,
    input  logic spi_mosi,
    input  logic spi_ss,
    output logic spi_miso,
    output logic phys_sck,
    output logic phys_mosi,
    output logic phys_cs,
    input  logic phys_miso,
    output logic virt_sck,
    output logic virt_mosi,
    output logic virt_ss,
    input  logic virt_miso,
    output logic vsd_sel,
    output logic switch_busy,
    output logic sd_act,
    output logic led_user,
    output logic led_disk
);

    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    route_state_t  state_q;
    logic          vsd_sel_q;
    logic          switch_busy_q;
    logic          target_q;
    logic [QW-1:0] quiet_q;
    logic          phys_miso_s;

`ifdef SD_MISO_SYNC_EN
    logic [1:0] miso_sync_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            miso_sync_q <= 2'b11;
        end else begin
            miso_sync_q <= {miso_sync_q[0], phys_miso};
        end
    end

    assign phys_miso_s = miso_sync_q[1];
`else
    assign phys_miso_s = phys_miso;
`endif

    // The FSM reads target_q from before this edge, so a mount strobe that
    // coincides with quiet-count completion is only seen in the next state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PHYS;
            vsd_sel_q     <= 1'b0;
            switch_busy_q <= 1'b0;
            target_q      <= 1'b0;
            quiet_q       <= '0;
        end else begin
            if (img_mounted) begin
                target_q <= img_size_nz;
            end
            case (state_q)
                PHYS: begin
                    if (target_q) begin
                        state_q       <= DRAIN_V;
                        switch_busy_q <= 1'b1;
                        quiet_q       <= '0;
                    end
                end
                VIRT: begin
                    if (!target_q) begin
                        state_q       <= DRAIN_P;
                        switch_busy_q <= 1'b1;
                        quiet_q       <= '0;
                    end
                end
                DRAIN_V, DRAIN_P: begin
                    if (target_q == vsd_sel_q) begin
                        state_q       <= vsd_sel_q ? VIRT : PHYS;
                        switch_busy_q <= 1'b0;
                        quiet_q       <= '0;
                    end else if (!spi_ss) begin
                        quiet_q <= '0;
                    end else if (quiet_q == QUIET_LAST) begin
                        state_q       <= vsd_sel_q ? PHYS : VIRT;
                        vsd_sel_q     <= ~vsd_sel_q;
                        switch_busy_q <= 1'b0;
                        quiet_q       <= '0;
                    end else begin
                        quiet_q <= quiet_q + QW'(1);
                    end
                end
                default: begin
                    state_q       <= PHYS;
                    vsd_sel_q     <= 1'b0;
                    switch_busy_q <= 1'b0;
                    quiet_q       <= '0;
                end
            endcase
        end
    end

    // The deselected card is parked with CS high and SCK/MOSI low.
    assign phys_sck  = vsd_sel_q ? 1'b0 : spi_sck;
    assign phys_mosi = vsd_sel_q ? 1'b0 : spi_mosi;
    assign phys_cs   = vsd_sel_q ? 1'b1 : spi_ss;
    assign virt_sck  = vsd_sel_q ? spi_sck  : 1'b0;
    assign virt_mosi = vsd_sel_q ? spi_mosi : 1'b0;
    assign virt_ss   = vsd_sel_q ? spi_ss   : 1'b1;
    assign spi_miso  = vsd_sel_q ? virt_miso : phys_miso_s;

    sd_act_timer #(
        .ACT_TIMEOUT (ACT_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_act_timer (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .mosi_i   (spi_mosi),
        .miso_i   (spi_miso),
        .sd_act_o (sd_act)
    );

    assign vsd_sel     = vsd_sel_q;
    assign switch_busy = switch_busy_q;
    assign led_user    = vsd_sel_q & sd_act;
    assign led_disk    = ~vsd_sel_q & sd_act;

endmodule

// File: tb/tb_sd_route_ctrl.sv
// Scoreboard bench for sd_route_ctrl: stimulus queues expected output values,
// a negedge monitor pops and compares them against the DUT.
module tb_sd_route_ctrl;

    localparam int QUIET = 64;
    localparam int ACT   = 100;

    localparam int S_VSD   = 0;
    localparam int S_BUSY  = 1;
    localparam int S_ACT   = 2;
    localparam int S_LUSER = 3;
    localparam int S_LDISK = 4;
    localparam int S_PCS   = 5;
    localparam int S_VSS   = 6;
    localparam int S_MISO  = 7;
    localparam int S_PSCK  = 8;
    localparam int S_VSCK  = 9;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic img_mounted, img_size_nz;
    logic spi_sck, spi_mosi, spi_ss, spi_miso;
    logic phys_sck, phys_mosi, phys_cs, phys_miso;
    logic virt_sck, virt_mosi, virt_ss, virt_miso;
    logic vsd_sel, switch_busy, sd_act, led_user, led_disk;

    int vectors     = 0;
    int miscompares = 0;

    int    sb_sig[$];
    logic  sb_val[$];
    string sb_name[$];

    sd_route_ctrl #(
        .QUIET_CYCLES (QUIET),
        .ACT_TIMEOUT  (ACT),
        .CNT_W        (8)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .img_mounted (img_mounted),
        .img_size_nz (img_size_nz),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_ss      (spi_ss),
        .spi_miso    (spi_miso),
        .phys_sck    (phys_sck),
        .phys_mosi   (phys_mosi),
        .phys_cs     (phys_cs),
        .phys_miso   (phys_miso),
        .virt_sck    (virt_sck),
        .virt_mosi   (virt_mosi),
        .virt_ss     (virt_ss),
        .virt_miso   (virt_miso),
        .vsd_sel     (vsd_sel),
        .switch_busy (switch_busy),
        .sd_act      (sd_act),
        .led_user    (led_user),
        .led_disk    (led_disk)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic get_sig(input int s);
        case (s)
            S_VSD:   return vsd_sel;
            S_BUSY:  return switch_busy;
            S_ACT:   return sd_act;
            S_LUSER: return led_user;
            S_LDISK: return led_disk;
            S_PCS:   return phys_cs;
            S_VSS:   return virt_ss;
            S_MISO:  return spi_miso;
            S_PSCK:  return phys_sck;
            S_VSCK:  return virt_sck;
            default: return 1'bx;
        endcase
    endfunction

    task automatic chk(input string name, input int s, input logic v);
        sb_sig.push_back(s);
        sb_val.push_back(v);
        sb_name.push_back(name);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    always @(negedge clk_sys) begin
        while (sb_sig.size() > 0) begin
            automatic int    s = sb_sig.pop_front();
            automatic logic  v = sb_val.pop_front();
            automatic string n = sb_name.pop_front();
            automatic logic  a = get_sig(s);
            vectors++;
            if (a !== v) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b at %0t", n, a, v, $time);
            end else begin
                $display("check %s: got %b at %0t", n, a, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; img_mounted = 1'b0; img_size_nz = 1'b0;
        spi_sck = 1'b0; spi_mosi = 1'b0; spi_ss = 1'b1;
        phys_miso = 1'b1; virt_miso = 1'b0;
        #2;
        chk("rst_vsd", S_VSD, 1'b0);
        chk("rst_busy", S_BUSY, 1'b0);
        chk("rst_act", S_ACT, 1'b0);
        chk("rst_phys_cs", S_PCS, 1'b1);
        chk("rst_virt_ss", S_VSS, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();

        // Mount to virtual with the bus idle: 64 busy cycles then swap
        img_mounted = 1'b1; img_size_nz = 1'b1;
        tick();
        img_mounted = 1'b0;
        chk("mnt_busy_pre", S_BUSY, 1'b0);
        tick();
        for (int i = 0; i < QUIET; i++) begin
            chk("drain_v_busy", S_BUSY, 1'b1);
            chk("drain_v_vsd", S_VSD, 1'b0);
            tick();
        end
        chk("swap_vsd", S_VSD, 1'b1);
        chk("swap_busy", S_BUSY, 1'b0);
        chk("swap_act", S_ACT, 1'b0);
        spi_ss = 1'b0; spi_sck = 1'b1;
        chk("virt_ss_follow", S_VSS, 1'b0);
        chk("phys_cs_parked", S_PCS, 1'b1);
        chk("virt_sck_follow", S_VSCK, 1'b1);
        chk("phys_sck_parked", S_PSCK, 1'b0);
        tick();
        chk("act_after_miso_swap", S_ACT, 1'b1);
        chk("led_user_virt", S_LUSER, 1'b1);
        chk("led_disk_virt", S_LDISK, 1'b0);
        virt_miso = 1'b1;
        chk("miso_from_virt", S_MISO, 1'b1);
        spi_ss = 1'b1; spi_sck = 1'b0;
        tick();

        // Unmount back to physical
        img_mounted = 1'b1; img_size_nz = 1'b0;
        tick();
        img_mounted = 1'b0;
        tick();
        chk("drain_p_busy", S_BUSY, 1'b1);
        chk("drain_p_vsd", S_VSD, 1'b1);
        repeat (QUIET - 1) tick();
        chk("drain_p_last_vsd", S_VSD, 1'b1);
        tick();
        chk("unmount_vsd", S_VSD, 1'b0);
        chk("unmount_busy", S_BUSY, 1'b0);

        // Abort a pending swap by re-mounting the current route
        img_mounted = 1'b1; img_size_nz = 1'b1;
        tick();
        img_mounted = 1'b0;
        tick();
        chk("abort_busy_in", S_BUSY, 1'b1);
        repeat (5) tick();
        img_mounted = 1'b1; img_size_nz = 1'b0;
        tick();
        img_mounted = 1'b0;
        chk("abort_busy_edge", S_BUSY, 1'b1);
        tick();
        chk("abort_busy_out", S_BUSY, 1'b0);
        chk("abort_vsd", S_VSD, 1'b0);
        repeat (70) tick();
        chk("abort_vsd_hold", S_VSD, 1'b0);
        chk("abort_busy_hold", S_BUSY, 1'b0);

        // Activity timer from a single MOSI toggle
        repeat (40) tick();
        chk("act_idle", S_ACT, 1'b0);
        chk("led_disk_idle", S_LDISK, 1'b0);
        spi_mosi = 1'b1;
        for (int k = 1; k <= ACT; k++) begin
            tick();
            chk("act_high", S_ACT, 1'b1);
            chk("led_disk_high", S_LDISK, 1'b1);
            chk("led_user_low", S_LUSER, 1'b0);
        end
        tick();
        chk("act_expired", S_ACT, 1'b0);
        chk("led_disk_expired", S_LDISK, 1'b0);

        // Physical MISO path latency
        phys_miso = 1'b0;
`ifdef SD_MISO_SYNC_EN
        chk("miso_sync_0", S_MISO, 1'b1);
        tick();
        chk("miso_sync_1", S_MISO, 1'b1);
        tick();
        chk("miso_sync_2", S_MISO, 1'b0);
`else
        chk("miso_direct", S_MISO, 1'b0);
        tick();
`endif
        phys_miso = 1'b1;
        repeat (3) tick();

        // Mount while the core holds CS low; a CS blip restarts the quiet count
        spi_ss = 1'b0;
        img_mounted = 1'b1; img_size_nz = 1'b1;
        tick();
        img_mounted = 1'b0;
        tick();
        for (int i = 0; i < 200; i++) begin
            chk("cs_low_busy", S_BUSY, 1'b1);
            chk("cs_low_vsd", S_VSD, 1'b0);
            tick();
        end
        spi_ss = 1'b1;
        repeat (30) tick();
        chk("quiet30_vsd", S_VSD, 1'b0);
        spi_ss = 1'b0;
        tick();
        spi_ss = 1'b1;
        repeat (QUIET - 1) tick();
        chk("restart_vsd", S_VSD, 1'b0);
        chk("restart_busy", S_BUSY, 1'b1);
        tick();
        chk("restart_swap_vsd", S_VSD, 1'b1);
        chk("restart_swap_busy", S_BUSY, 1'b0);

        // Asynchronous reset while routed to virtual
        spi_ss = 1'b0;
        spi_mosi = 1'b0;
        tick();
        chk("pre_rst_act", S_ACT, 1'b1);
        chk("pre_rst_virt_ss", S_VSS, 1'b0);
        @(posedge clk_sys);
        #3;
        reset_n = 1'b0;
        chk("arst_vsd", S_VSD, 1'b0);
        chk("arst_phys_cs", S_PCS, 1'b0);
        chk("arst_virt_ss", S_VSS, 1'b1);
        chk("arst_act", S_ACT, 1'b0);
        chk("arst_busy", S_BUSY, 1'b0);
        chk("arst_led_user", S_LUSER, 1'b0);
        tick();
        reset_n = 1'b1;
        spi_ss = 1'b1;
        tick();
        tick();
        chk("post_rst_vsd", S_VSD, 1'b0);
        chk("post_rst_busy", S_BUSY, 1'b0);

        @(negedge clk_sys);
        @(negedge clk_sys);
        vectors++;
        if (sb_sig.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_sig.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_route_ctrl.md
Name: sd_route_ctrl

Overview:
Owns the shared SPI port of the MMC/SD interface in the emsx core and routes it to either the physical SD slot or the virtual (HPS-image) sd_card. Switchover on image mount is glitch-free: the swap waits until the core's SPI transaction is over and the bus has been quiet for a set time. Also produces the SD activity timer that drives the user and disk LEDs. Sits between emsx_top's mmc_* pins, the board SD pins and sd_card.

Parameters:
QUIET_CYCLES, 64, consecutive clk_sys cycles with spi_ss high required before a route swap
ACT_TIMEOUT, 1000000, clk_sys cycles sd_act stays high after the last bus toggle
CNT_W, 20, width of the activity counter; must satisfy 2**CNT_W > ACT_TIMEOUT

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous reset, active low
img_mounted  in  1  one-cycle mount strobe from hps_io
img_size_nz  in  1  OR-reduction of img_size; sampled when img_mounted is high
spi_sck  in  1  core SPI clock
spi_mosi  in  1  core SPI data out
spi_ss  in  1  core chip select, active low
spi_miso  out  1  data returned to the core
phys_sck  out  1  SD_SCK
phys_mosi  out  1  SD_MOSI
phys_cs  out  1  SD_CS, active low
phys_miso  in  1  SD_MISO
virt_sck  out  1  SPI clock to sd_card
virt_mosi  out  1  SPI data to sd_card
virt_ss  out  1  chip select to sd_card, active low
virt_miso  in  1  data from sd_card
vsd_sel  out  1  1 = virtual card routed
switch_busy  out  1  a route swap is pending
sd_act  out  1  activity flag
led_user  out  1  vsd_sel & sd_act
led_disk  out  1  ~vsd_sel & sd_act

Behaviour:
- FSM states: PHYS, DRAIN_V, VIRT, DRAIN_P. Reset state is PHYS.
- Reset values: vsd_sel=0, switch_busy=0, quiet counter=0, target=0, activity counter=ACT_TIMEOUT, sd_act=0. All registered outputs reset to these values asynchronously.
- target register: loaded with img_size_nz on every cycle img_mounted=1. Otherwise it holds its value.
- PHYS: if target=1, go to DRAIN_V. VIRT: if target=0, go to DRAIN_P.
- DRAIN_x:
  - The current routing stays unchanged. The quiet counter increments while spi_ss=1 and clears to 0 whenever spi_ss=0.
  - When the counter reaches QUIET_CYCLES-1 while spi_ss=1, the next cycle enters the new stable state, toggles vsd_sel and clears the counter.
  - If target changes back to the current route during drain, return to the current stable state on the next cycle. vsd_sel does not change.
- switch_busy=1 exactly in the DRAIN states (registered state decode).
- A mount strobe on the same cycle as the quiet-count completion: the swap uses the target value latched before that edge. The new target is evaluated in the following state.
- Routing is combinational from vsd_sel:
  - vsd_sel=0: phys_sck=spi_sck, phys_mosi=spi_mosi, phys_cs=spi_ss, virt_ss=1, virt_sck=0, virt_mosi=0, spi_miso=phys_miso.
  - vsd_sel=1: the mirror image, with phys_cs=1, phys_sck=0, phys_mosi=0 and spi_miso=virt_miso.
  - The deselected card never sees a chip-select assertion.
- Activity:
  - Register the previous spi_mosi and spi_miso values.
  - On any toggle of either, clear the counter to 0.
  - Otherwise the counter increments, saturating at ACT_TIMEOUT.
  - sd_act is registered and equals (counter < ACT_TIMEOUT), so it rises one cycle after the toggle.
- Reset mid-drain: returns to PHYS with vsd_sel=0, even if VIRT was the active route.

Optional Feature:
SD_MISO_SYNC_EN.
- Defined: phys_miso passes through a two-flop synchronizer in clk_sys, reset to 1, before the spi_miso mux and the activity detector. This adds 2 cycles of latency on the physical path only.
- Undefined: phys_miso is used directly and combinationally.

Decomposition:
- Package sd_route_pkg holds:
  - route_state_t enum (PHYS, DRAIN_V, VIRT, DRAIN_P)
  - localparam defaults for QUIET_CYCLES and ACT_TIMEOUT
- One natural sub-module, sd_act_timer: the edge detector plus saturating counter producing sd_act.

Test Plan:
- Reset, then mount with img_size_nz=1 while spi_ss=1 held → switch_busy=1 for 64 cycles; vsd_sel rises on cycle 65; virt_ss follows spi_ss, phys_cs stays 1.
- Mount to virtual while spi_ss=0, then release spi_ss after 200 cycles → vsd_sel stays 0 until 64 quiet cycles after the release; a spi_ss pulse low at quiet count 30 restarts the count.
- In DRAIN_V, pulse img_mounted with img_size_nz=0 → FSM returns to PHYS next cycle; switch_busy=0; vsd_sel never toggles.
- Single spi_mosi toggle, ACT_TIMEOUT=100 → sd_act high from cycle +1 for 100 cycles; led_user/led_disk follow vsd_sel.
- Assert reset_n=0 mid-VIRT with spi_ss=0 → vsd_sel=0, phys_cs=spi_ss, virt_ss=1, sd_act=0 immediately (asynchronous).
- With SD_MISO_SYNC_EN: toggle phys_miso, vsd_sel=0 → spi_miso changes after exactly 2 clk_sys edges.
